tender_grp_classifier: RTL and testbench

//   Parametrised TENDER channel-grouping engine for RT_TENDER. Buffers one frame of NUM_CH signed

---
 rtl/tender_grp_classifier.sv | 124 ++++++++++++
 tb/tb_tender_grp_classifier.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tender_grp_classifier.sv
// Buffers one frame of NUM_CH signed activations, tracks the frame max |x|, then streams each channel with its power-of-two group.
// Latency: first out_valid one cycle after the last accept of a frame; outputs are registered-state driven (no in->out comb path).
// Backpressure: in_ready low for the whole EMIT phase; EMIT outputs hold steady while out_valid && !out_ready.
module tender_grp_classifier #(
    parameter int DATA_W  = 8,
    parameter int NUM_CH  = 8,
    parameter int NUM_GRP = 4,
    localparam int CH_W   = $clog2(NUM_CH),
    localparam int IDX_W  = $clog2(NUM_GRP)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic [IDX_W-1:0]         out_grp,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic [DATA_W-1:0]        max_val,
    output logic                     busy
);

    typedef enum logic {
        SCAN = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t                     state_q, state_d;
    logic                       live_q;
    logic [CH_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0]          acc_q, max_q;
    logic signed [DATA_W-1:0]   smp_mem [NUM_CH];
    logic [DATA_W-1:0]          abs_mem [NUM_CH];

    logic [DATA_W-1:0]          in_u, in_abs, acc_nxt;
    logic                       accept, xfer, wr_last, rd_last;

    // |x| as DATA_W-bit unsigned: the most negative code maps to 2^(DATA_W-1) without saturating
    assign in_u    = in_data;
    assign in_abs  = in_u[DATA_W-1] ? (~in_u + DATA_W'(1)) : in_u;

    // first accept of a frame loads the accumulator so the previous frame never leaks in
    assign acc_nxt = ((wr_ptr_q == '0) || (in_abs > acc_q)) ? in_abs : acc_q;

    assign in_ready  = live_q && (state_q == SCAN);
    assign out_valid = (state_q == EMIT);
    assign busy      = out_valid;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign wr_last   = (wr_ptr_q == LAST_CH);
    assign rd_last   = (rd_ptr_q == LAST_CH);

    assign out_ch    = rd_ptr_q;
    assign out_data  = smp_mem[rd_ptr_q];
    assign out_last  = out_valid && rd_last;
    assign max_val   = max_q;

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // next state: leave SCAN on the final accept, leave EMIT on the final transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN:    if (accept && wr_last) state_d = EMIT;
            EMIT:    if (xfer && rd_last)   state_d = SCAN;
            default: state_d = SCAN;
        endcase
    end

    // pointers, running max and the published frame max
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            live_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            acc_q    <= '0;
            max_q    <= '0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                acc_q <= acc_nxt;
                if (wr_last) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    max_q    <= acc_nxt;
                end else begin
                    wr_ptr_q <= wr_ptr_q + CH_W'(1);
                end
            end
            if (xfer) begin
                rd_ptr_q <= rd_last ? '0 : (rd_ptr_q + CH_W'(1));
            end
        end
    end

    // frame buffer: raw sample plus its magnitude, no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            smp_mem[wr_ptr_q] <= in_data;
            abs_mem[wr_ptr_q] <= in_abs;
        end
    end

    // group = smallest k with |x| > max>>(k+1); scanning downward lets the smallest k win
    always_comb begin
        out_grp = IDX_W'(NUM_GRP - 1);
        for (int k = NUM_GRP - 2; k >= 0; k--) begin
            if (abs_mem[rd_ptr_q] > (max_q >> (k + 1))) out_grp = IDX_W'(k);
        end
    end

endmodule

// File: tb/tb_tender_grp_classifier.sv
module tb_tender_grp_classifier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    // instance 0: default parameters
    logic              a_iv, a_ir, a_ov, a_or, a_last, a_busy;
    logic signed [7:0] a_id, a_od;
    logic [2:0]        a_ch;
    logic [1:0]        a_grp;
    logic [7:0]        a_mv;

    // instance 1: wide sweep configuration
    logic               b_iv, b_ir, b_ov, b_or, b_last, b_busy;
    logic signed [11:0] b_id, b_od;
    logic [3:0]         b_ch;
    logic [2:0]         b_grp;
    logic [11:0]        b_mv;

    tender_grp_classifier u_a (
        .clk(clk), .rstn(rstn), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_ch(a_ch), .out_grp(a_grp),
        .out_data(a_od), .out_last(a_last), .max_val(a_mv), .busy(a_busy)
    );

    tender_grp_classifier #(.DATA_W(12), .NUM_CH(16), .NUM_GRP(8)) u_b (
        .clk(clk), .rstn(rstn), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_ch(b_ch), .out_grp(b_grp),
        .out_data(b_od), .out_last(b_last), .max_val(b_mv), .busy(b_busy)
    );

    typedef struct {
        int ch;
        int grp;
        int data;
        int last;
        int mv;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   bp[2];

    int   frm[16];
    int   gx[16];
    int   fr_def[8] = '{100, -60, 30, 12, 5, -128, 64, 0};
    int   gx_def[8] = '{0, 1, 2, 3, 3, 0, 1, 3};
    int   fr_bnd[8] = '{-64, 32, 16, 8, 33, 1, 2, 3};
    int   gx_bnd[8] = '{0, 1, 2, 3, 0, 3, 3, 3};
    int   fr_rst[8] = '{7, 1, 2, 3, 4, 5, 6, 0};

    task automatic chk(input int inst, input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL u%0d %s: got %0d expected %0d", inst, nm, act, exp);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // reference: group is the first halving of the frame max that |x| strictly exceeds
    function automatic int ref_grp(input int x, input int m, input int ngrp);
        for (int k = 0; k < ngrp - 1; k++)
            if (iabs(x) > m / (2 ** (k + 1))) return k;
        return ngrp - 1;
    endfunction

    function automatic int qsize(input int sel);
        return (sel == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push_exp(input int sel, input int nch, input int ngrp, input bit use_g, input int mv_c);
        int   m;
        exp_t e;
        m = 0;
        for (int c = 0; c < nch; c++) if (iabs(frm[c]) > m) m = iabs(frm[c]);
        if (use_g) m = mv_c;
        for (int c = 0; c < nch; c++) begin
            e.ch   = c;
            e.grp  = use_g ? gx[c] : ref_grp(frm[c], m, ngrp);
            e.data = frm[c];
            e.last = (c == nch - 1) ? 1 : 0;
            e.mv   = m;
            if (sel == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic send(input int sel, input int d);
        int guard;
        guard = 0;
        if (sel == 0) begin a_iv = 1'b1; a_id = 8'(d); end
        else          begin b_iv = 1'b1; b_id = 12'(d); end
        while (((sel == 0) ? a_ir : b_ir) !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 3000) begin
                n_cmp++; n_fail++;
                $display("FAIL u%0d in_ready_timeout: got 0 expected 1", sel);
                break;
            end
        end
        @(negedge clk);
        a_iv = 1'b0;
        b_iv = 1'b0;
    endtask

    task automatic send_frame(input int sel, input int nch, input bit gaps);
        for (int c = 0; c < nch; c++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) repeat ($urandom_range(1, 3)) @(negedge clk);
            send(sel, frm[c]);
        end
    endtask

    task automatic rand_frame(input int nch, input int dw);
        int amp;
        amp = $urandom_range(1, dw);
        for (int c = 0; c < nch; c++)
            frm[c] = int'($urandom_range(0, (1 << amp) - 1)) - (1 << (amp - 1));
    endtask

    task automatic drain(input int sel);
        int g;
        g = 0;
        while (qsize(sel) != 0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk(sel, "drain_left", qsize(sel), 0);
    endtask

    // downstream ready: either always accepting or randomly stalling
    initial begin
        a_or = 1'b1;
        b_or = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            a_or = bp[0] ? 1'($urandom_range(0, 1)) : 1'b1;
            b_or = bp[1] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // scoreboard monitor for both instances
    bit stall[2];
    int s_ch[2], s_grp[2], s_data[2], s_last[2];
    always @(negedge clk) begin
        logic ov, orr, ir, lst, bz;
        int   ch, grp, dat, mv;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                ov = a_ov; orr = a_or; ir = a_ir; lst = a_last; bz = a_busy;
                ch = int'(a_ch); grp = int'(a_grp); dat = int'(a_od); mv = int'(a_mv);
            end else begin
                ov = b_ov; orr = b_or; ir = b_ir; lst = b_last; bz = b_busy;
                ch = int'(b_ch); grp = int'(b_grp); dat = int'(b_od); mv = int'(b_mv);
            end
            if (rstn && ov) begin
                chk(i, "in_ready_during_emit", int'(ir), 0);
                chk(i, "busy_during_emit", int'(bz), 1);
                if (stall[i]) begin
                    chk(i, "stall_ch", ch, s_ch[i]);
                    chk(i, "stall_grp", grp, s_grp[i]);
                    chk(i, "stall_data", dat, s_data[i]);
                    chk(i, "stall_last", int'(lst), s_last[i]);
                end
                if (orr) begin
                    if (qsize(i) == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL u%0d unexpected_output: got ch %0d expected none", i, ch);
                    end else begin
                        if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
                        chk(i, "out_ch", ch, e.ch);
                        chk(i, "out_grp", grp, e.grp);
                        chk(i, "out_data", dat, e.data);
                        chk(i, "out_last", int'(lst), e.last);
                        chk(i, "max_val", mv, e.mv);
                    end
                end
                stall[i]  = !orr;
                s_ch[i]   = ch;
                s_grp[i]  = grp;
                s_data[i] = dat;
                s_last[i] = int'(lst);
            end else begin
                stall[i] = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        a_iv = 1'b0; a_id = '0;
        b_iv = 1'b0; b_id = '0;
        bp[0] = 1'b0; bp[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk(0, "rst_out_valid", int'(a_ov), 0);
        chk(0, "rst_busy", int'(a_busy), 0);
        chk(0, "rst_out_last", int'(a_last), 0);
        chk(0, "rst_max_val", int'(a_mv), 0);
        chk(1, "rst_out_valid", int'(b_ov), 0);
        rstn = 1'b1;
        @(negedge clk);
        chk(0, "in_ready_after_rst", int'(a_ir), 1);
        chk(1, "in_ready_after_rst", int'(b_ir), 1);

        // reference frame, first-output latency
        foreach (fr_def[c]) begin frm[c] = fr_def[c]; gx[c] = gx_def[c]; end
        push_exp(0, 8, 4, 1'b1, 128);
        send_frame(0, 8, 1'b0);
        chk(0, "first_valid_latency", int'(a_ov), 1);
        drain(0);
        repeat (2) @(negedge clk);
        chk(0, "max_val_hold_scan", int'(a_mv), 128);
        chk(0, "in_ready_back", int'(a_ir), 1);

        // equality at a threshold drops to the next group
        foreach (fr_bnd[c]) begin frm[c] = fr_bnd[c]; gx[c] = gx_bnd[c]; end
        push_exp(0, 8, 4, 1'b1, 64);
        send_frame(0, 8, 1'b0);
        drain(0);

        // all-zero frame then all-ones frame
        for (int c = 0; c < 8; c++) begin frm[c] = 0; gx[c] = 3; end
        push_exp(0, 8, 4, 1'b1, 0);
        send_frame(0, 8, 1'b0);
        for (int c = 0; c < 8; c++) begin frm[c] = 1; gx[c] = 0; end
        push_exp(0, 8, 4, 1'b1, 1);
        send_frame(0, 8, 1'b0);
        drain(0);

        // random backpressure and input gaps
        bp[0] = 1'b1;
        for (int f = 0; f < 20; f++) begin
            rand_frame(8, 8);
            push_exp(0, 8, 4, 1'b0, 0);
            send_frame(0, 8, 1'b1);
        end
        drain(0);
        bp[0] = 1'b0;

        // reset in the middle of a frame discards it
        send(0, 120);
        send(0, -100);
        send(0, 90);
        rstn = 1'b0;
        @(negedge clk);
        chk(0, "midframe_rst_max", int'(a_mv), 0);
        chk(0, "midframe_rst_valid", int'(a_ov), 0);
        rstn = 1'b1;
        @(negedge clk);
        foreach (fr_rst[c]) frm[c] = fr_rst[c];
        push_exp(0, 8, 4, 1'b0, 0);
        send_frame(0, 8, 1'b0);
        drain(0);
        chk(0, "max_after_rst_frame", int'(a_mv), 7);

        // wide configuration sweep
        bp[1] = 1'b1;
        for (int f = 0; f < 200; f++) begin
            rand_frame(16, 12);
            push_exp(1, 16, 8, 1'b0, 0);
            send_frame(1, 16, 1'b1);
        end
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
